// File: rtl/spi_slave_core.sv
// spi_slave_core: parametrised SPI slave with internal input synchronisers, all CPOL/CPHA modes, MSB/LSB order and multi-word frames.
// Latency: raw sample edge of a word's last bit -> rx_valid after SYNC_STAGES+2 Clk edges; LOAD takes 1 cycle after cs_n falls.
// Backpressure: none toward the master; tx_load is accepted only while tx_ready=1. Optional SPI_SLAVE_ECHO_EN makes an empty tx buffer echo rx_data.
module spi_slave_core #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter bit CPOL        = 1'b0,
    parameter bit CPHA        = 1'b0,
    parameter bit MSB_FIRST   = 1'b1
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             sclk,
    input  logic             cs_n,
    input  logic             mosi,
    output logic             miso,
    output logic             miso_oe,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_load,
    output logic             tx_ready,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);

    typedef enum logic [1:0] {IDLE, LOAD, ACTIVE} state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   sclk_dly_q, cs_dly_q;
    logic [WIDTH-1:0]       tx_shift_q, tx_shift_d;
    logic [WIDTH-1:0]       rx_shift_q, rx_shift_d;
    logic [WIDTH-1:0]       txbuf_q, txbuf_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   hold_q, hold_d;
    logic                   miso_q, miso_d;
    logic                   miso_oe_q, miso_oe_d;
    logic                   tx_ready_q, tx_ready_d;
    logic [WIDTH-1:0]       rx_data_q, rx_data_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   busy_q, busy_d;

    logic sclk_s, cs_s, mosi_s;
    logic lead_e, trail_e, sample_e, shift_e, cs_fall, cs_rise;
    logic xfer;
    logic [WIDTH-1:0] empty_word;

    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s   = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    // Edge detection on the synchronised pins; sample/shift roles swap with CPHA.
    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs_n};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
        lead_e      = (sclk_dly_q == CPOL) && (sclk_s != CPOL);
        trail_e     = (sclk_dly_q != CPOL) && (sclk_s == CPOL);
        sample_e    = CPHA ? trail_e : lead_e;
        shift_e     = CPHA ? lead_e : trail_e;
        cs_fall     = cs_dly_q && !cs_s;
        cs_rise     = !cs_dly_q && cs_s;
    end

    // Word loaded into the shifter when the tx buffer is empty at a transfer.
    always_comb begin
`ifdef SPI_SLAVE_ECHO_EN
        // At a word completion the just-finished word is still in rx_shift_q.
        empty_word = (state_q == ACTIVE) ? rx_shift_q : rx_data_q;
`else
        empty_word = '0;
`endif
    end

    // Frame FSM, shift registers, tx buffer handshake and registered outputs.
    always_comb begin
        state_d    = state_q;
        tx_shift_d = tx_shift_q;
        rx_shift_d = rx_shift_q;
        txbuf_d    = txbuf_q;
        cnt_d      = cnt_q;
        hold_d     = hold_q;
        tx_ready_d = tx_ready_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        xfer       = 1'b0;
        case (state_q)
            IDLE: begin
                if (cs_fall) state_d = LOAD;
            end
            LOAD: begin
                xfer       = 1'b1;
                cnt_d      = '0;
                rx_shift_d = '0;
                // CPHA=1: the first leading edge only presents bit 0.
                hold_d     = CPHA;
                state_d    = ACTIVE;
            end
            ACTIVE: begin
                if (cnt_q == CNT_FULL) begin
                    rx_data_d  = rx_shift_q;
                    rx_valid_d = 1'b1;
                    cnt_d      = '0;
                    // Reload for the next word; the next shift edge keeps its bit 0.
                    if (!cs_rise) begin
                        xfer   = 1'b1;
                        hold_d = 1'b1;
                    end
                end else begin
                    if (sample_e) begin
                        if (MSB_FIRST) rx_shift_d = {rx_shift_q[WIDTH-2:0], mosi_s};
                        else           rx_shift_d = {mosi_s, rx_shift_q[WIDTH-1:1]};
                        cnt_d = cnt_q + CW'(1);
                    end
                    if (shift_e) begin
                        if (hold_q)         hold_d     = 1'b0;
                        else if (MSB_FIRST) tx_shift_d = {tx_shift_q[WIDTH-2:0], 1'b0};
                        else                tx_shift_d = {1'b0, tx_shift_q[WIDTH-1:1]};
                    end
                end
                if (cs_rise) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
        // Transfer takes the old buffer contents before any same-cycle capture.
        if (xfer) begin
            tx_shift_d = tx_ready_q ? empty_word : txbuf_q;
            tx_ready_d = 1'b1;
        end
        if (tx_load && tx_ready_q) begin
            txbuf_d    = tx_data;
            tx_ready_d = 1'b0;
        end
        miso_d    = MSB_FIRST ? tx_shift_d[WIDTH-1] : tx_shift_d[0];
        miso_oe_d = (state_d == ACTIVE);
        busy_d    = (state_d != IDLE);
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= IDLE;
            sclk_sync_q <= {SYNC_STAGES{CPOL}};
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sclk_dly_q  <= CPOL;
            cs_dly_q    <= 1'b1;
            tx_shift_q  <= '0;
            rx_shift_q  <= '0;
            txbuf_q     <= '0;
            cnt_q       <= '0;
            hold_q      <= 1'b0;
            miso_q      <= 1'b0;
            miso_oe_q   <= 1'b0;
            tx_ready_q  <= 1'b1;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sclk_sync_q <= sclk_sync_d;
            cs_sync_q   <= cs_sync_d;
            mosi_sync_q <= mosi_sync_d;
            sclk_dly_q  <= sclk_s;
            cs_dly_q    <= cs_s;
            tx_shift_q  <= tx_shift_d;
            rx_shift_q  <= rx_shift_d;
            txbuf_q     <= txbuf_d;
            cnt_q       <= cnt_d;
            hold_q      <= hold_d;
            miso_q      <= miso_d;
            miso_oe_q   <= miso_oe_d;
            tx_ready_q  <= tx_ready_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign miso     = miso_q;
    assign miso_oe  = miso_oe_q;
    assign tx_ready = tx_ready_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign busy     = busy_q;

endmodule
